// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte holding register and valid/ready handshake
module uart_rx #(
    parameter int CLK_HZ       = 25000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state, state_next;
    logic        rx_meta, rxs;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shift, shift_next;
    logic        deliver, ferr_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        deliver    = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[7:1]};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A delivery coincident with a consume refills the register without a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int CLK_HZ = 25000000;
    localparam int BAUD   = 115200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int LAT    = 2 + HALF + 9 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_start = 0;

    byte unsigned got_mem [0:255];
    int   got_n    = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    int   rise_cyc = 0;
    logic valid_d  = 1'b0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc++;

    // Byte accepted whenever valid&&ready is seen; pulses counted per cycle high.
    always @(negedge clk) begin
        if (valid && ready && got_n < 256) begin
            got_mem[got_n] = data;
            got_n++;
        end
        if (valid && !valid_d) rise_cyc = cyc;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        valid_d = valid;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, required < 90000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        t_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        tick(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        reset = 1'b0;
        tick(10);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", valid); end
    endtask

    task automatic test_basic;
        int g0, f0, o0, lat;
        g0 = got_n; f0 = ferr_cnt; o0 = ovr_cnt;
        ready = 1'b1;
        send_frame(8'h55, 1'b1);
        tick(20);
        lat = rise_cyc - t_start;
        checks++; if (got_n - g0 !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", got_n - g0); end
        checks++; if (got_mem[g0] !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", got_mem[g0]); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", ferr_cnt - f0); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL basic_ovr got %0d exp 0", ovr_cnt - o0); end
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d+-2", lat, LAT);
        end
    endtask

    task automatic test_back_to_back;
        int g0, f0;
        g0 = got_n; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);
        checks++; if (got_n - g0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_n - g0); end
        checks++; if (got_mem[g0] !== 8'hA5) begin errors++; $display("FAIL b2b_data0 got %h exp a5", got_mem[g0]); end
        checks++; if (got_mem[g0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_data1 got %h exp 3c", got_mem[g0+1]); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch;
        int g0, f0;
        g0 = got_n; f0 = ferr_cnt;
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(300);
        checks++; if (got_n - g0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", got_n - g0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt - f0); end
        send_frame(8'h81, 1'b1);
        tick(20);
        checks++; if (got_mem[g0] !== 8'h81 || got_n - g0 !== 1) begin
            errors++; $display("FAIL glitch_next got %h/%0d exp 81/1", got_mem[g0], got_n - g0);
        end
    endtask

    task automatic test_frame_err;
        int g0, f0;
        g0 = got_n; f0 = ferr_cnt;
        send_frame(8'h12, 1'b0);
        rx = 1'b0;
        tick(2000);
        rx = 1'b1;
        tick(50);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt - f0); end
        checks++; if (got_n - g0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", got_n - g0); end
        send_frame(8'h34, 1'b1);
        tick(20);
        checks++; if (got_mem[g0] !== 8'h34 || got_n - g0 !== 1) begin
            errors++; $display("FAIL ferr_next got %h/%0d exp 34/1", got_mem[g0], got_n - g0);
        end
    endtask

    task automatic test_overrun;
        int g0, o0;
        g0 = got_n; o0 = ovr_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(5);
        send_frame(8'h22, 1'b1);
        tick(10);
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", valid); end
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", ovr_cnt - o0); end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_consume_valid got %b exp 0", valid); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_consume_data got %h exp 11", data); end
        checks++; if (got_n - g0 !== 1) begin errors++; $display("FAIL ovr_consume_count got %0d exp 1", got_n - g0); end
        ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int g0, f0;
        rx = 1'b0;
        tick(CPB * 4);
        tick(100);
        reset = 1'b1;
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL midrst_pulses got %b%b exp 00", frame_err, overrun);
        end
        tick(CPB - 100);
        g0 = got_n; f0 = ferr_cnt;
        rx = 1'b1;
        reset = 1'b0;
        tick(5 * CPB + 200);
        checks++; if (got_n - g0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL midrst_tail got %0d bytes %0d ferr exp 0 0", got_n - g0, ferr_cnt - f0);
        end
        send_frame(8'h0F, 1'b1);
        tick(20);
        checks++; if (got_mem[g0] !== 8'h0F || got_n - g0 !== 1) begin
            errors++; $display("FAIL midrst_next got %h/%0d exp 0f/1", got_mem[g0], got_n - g0);
        end
    endtask

    task automatic test_random;
        byte unsigned exp_q[$];
        int g0, f0, o0;
        logic [7:0] b;
        g0 = got_n; f0 = ferr_cnt; o0 = ovr_cnt;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            tick($urandom_range(0, 40));
        end
        tick(20);
        checks++; if (got_n - g0 !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", got_n - g0, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (got_mem[g0+i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_data%0d got %h exp %h", i, got_mem[g0+i], exp_q[i]);
            end
        end
        checks++; if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
            errors++; $display("FAIL rand_errs got %0d ferr %0d ovr exp 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid_frame;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
